// File: rtl/scsi_fifo_pkg.sv
// Shared definitions for the SCSI DMA FIFO.
// - Default depth and pointer width.
// - Byte-lane numbering for the big-endian (68k) lane layout, where lane 0 is the MSB.
// - Helpers that select a lane from a longword and build a lane write mask.
package scsi_fifo_pkg;

  localparam int unsigned DefaultDepth = 8;
  localparam int unsigned DefaultPtrW  = 3;

  // Lane numbers and the LSB of each lane inside a longword.
  localparam logic [1:0]  LANE0 = 2'd0;  // bits 31:24
  localparam logic [1:0]  LANE1 = 2'd1;  // bits 23:16
  localparam logic [1:0]  LANE2 = 2'd2;  // bits 15:8
  localparam logic [1:0]  LANE3 = 2'd3;  // bits 7:0
  localparam int unsigned LANE0_LSB = 24;
  localparam int unsigned LANE1_LSB = 16;
  localparam int unsigned LANE2_LSB = 8;
  localparam int unsigned LANE3_LSB = 0;

  // Byte slice of a longword addressed by a lane pointer.
  function automatic logic [7:0] lane_sel(input logic [31:0] lw, input logic [1:0] lane);
    logic [7:0] b;
    unique case (lane)
      LANE0:   b = lw[LANE0_LSB +: 8];
      LANE1:   b = lw[LANE1_LSB +: 8];
      LANE2:   b = lw[LANE2_LSB +: 8];
      default: b = lw[LANE3_LSB +: 8];
    endcase
    return b;
  endfunction

  // Write mask covering a single lane.
  function automatic logic [31:0] lane_mask(input logic [1:0] lane);
    logic [31:0] m;
    unique case (lane)
      LANE0:   m = 32'hFF00_0000;
      LANE1:   m = 32'h00FF_0000;
      LANE2:   m = 32'h0000_FF00;
      default: m = 32'h0000_00FF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/scsi_fifo_ptr.sv
// Entry pointer for the SCSI DMA FIFO, carrying an extra wrap bit.
// - An increment is refused while block_i is high, and the refused attempt sets the sticky
//   error flag.
// - A synchronous clear zeroes the pointer and the error flag, and overrides everything else.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clr_i          synchronous clear
//   inc_i          increment request
//   block_i        gate (FULL for next-in, EMPTY for next-out), sampled pre-edge
//   ptr_o          PtrW+1 bit pointer; the MSB is the wrap bit
//   err_o          sticky: increment attempted while blocked
module scsi_fifo_ptr #(
  parameter int unsigned PtrW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          block_i,
  output logic [PtrW:0] ptr_o,
  output logic          err_o
);

  logic [PtrW:0] ptr_d, ptr_q;
  logic          err_d, err_q;

  always_comb begin
    ptr_d = ptr_q;
    err_d = err_q;
    if (clr_i) begin
      ptr_d = '0;
      err_d = 1'b0;
    end else if (inc_i) begin
      if (block_i) begin
        err_d = 1'b1;
      end else begin
        ptr_d = ptr_q + {{PtrW{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  assign ptr_o = ptr_q;
  assign err_o = err_q;

endmodule

// File: rtl/scsi_dma_fifo.sv
// Longword-wide DMA FIFO between the host/DMA datapath and the 8-bit SCSI datapath.
// - Bytes are packed into entries and unpacked from them big-endian, with lane 0 holding
//   bits 31:24.
// - The pointers are driven by the INCNI/INCNO/INCBO strobes from the SCSI state machine.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset (clears storage too)
//   fifo_clr_i           synchronous clear of pointers and sticky flags, not storage
//   lw_we_i, lw_din_i    longword write into entry[NI]
//   byte_we_i, scsi_din_i  byte write into entry[NI] lane BI, then BI advances
//   incni_i              advance next-in and clear BI
//   incno_i              advance next-out and clear BO
//   incbo_i              advance byte-out lane
//   lw_dout_o            entry[NO], combinational
//   scsi_dout_o          lane BO of entry[NO]
//   bo_ptr_o, bi_ptr_o   current byte-out and byte-in lanes
//   level_o              occupied entries, 0..Depth
//   full_o, empty_o      level flags
//   ovf_o, unf_o         sticky overflow and underflow
module scsi_dma_fifo
  import scsi_fifo_pkg::*;
#(
  parameter int unsigned Depth = DefaultDepth,
  parameter int unsigned PtrW  = DefaultPtrW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fifo_clr_i,
  input  logic          lw_we_i,
  input  logic [31:0]   lw_din_i,
  input  logic          byte_we_i,
  input  logic [7:0]    scsi_din_i,
  input  logic          incni_i,
  input  logic          incno_i,
  input  logic          incbo_i,
  output logic [31:0]   lw_dout_o,
  output logic [7:0]    scsi_dout_o,
  output logic [1:0]    bo_ptr_o,
  output logic [1:0]    bi_ptr_o,
  output logic [PtrW:0] level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o,
  output logic          unf_o
);

  localparam logic [PtrW:0] LevelFull = (PtrW+1)'(Depth);

  logic [31:0]   mem_q [Depth];
  logic [PtrW:0] ni, no, level;
  logic          full, empty;
  logic [1:0]    bi_d, bi_q, bo_d, bo_q;
  logic          wr_en;
  logic [31:0]   wr_data, wr_mask;

  // Level uses modulo arithmetic; the wrap bit tells full apart from empty.
  assign level = ni - no;
  assign full  = (level == LevelFull);
  assign empty = (level == '0);

  scsi_fifo_ptr #(.PtrW(PtrW)) u_ni (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (fifo_clr_i),
    .inc_i   (incni_i),
    .block_i (full),
    .ptr_o   (ni),
    .err_o   (ovf_o)
  );

  scsi_fifo_ptr #(.PtrW(PtrW)) u_no (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (fifo_clr_i),
    .inc_i   (incno_i),
    .block_i (empty),
    .ptr_o   (no),
    .err_o   (unf_o)
  );

  // A longword write takes priority over a byte write. Writes are dropped while full.
  always_comb begin
    wr_en   = !fifo_clr_i && !full && (lw_we_i || byte_we_i);
    wr_data = lw_we_i ? lw_din_i : {4{scsi_din_i}};
    wr_mask = lw_we_i ? 32'hFFFF_FFFF : lane_mask(bi_q);
  end

  always_comb begin
    bi_d = bi_q;
    if (fifo_clr_i || incni_i) begin
      bi_d = 2'd0;
    end else if (byte_we_i && !lw_we_i && !full) begin
      bi_d = bi_q + 2'd1;
    end
  end

  always_comb begin
    bo_d = bo_q;
    if (fifo_clr_i || incno_i) begin
      bo_d = 2'd0;
    end else if (incbo_i) begin
      bo_d = bo_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bi_q <= 2'd0;
      bo_q <= 2'd0;
    end else begin
      bi_q <= bi_d;
      bo_q <= bo_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[ni[PtrW-1:0]] <= (mem_q[ni[PtrW-1:0]] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  assign lw_dout_o   = mem_q[no[PtrW-1:0]];
  assign scsi_dout_o = lane_sel(lw_dout_o, bo_q);
  assign bo_ptr_o    = bo_q;
  assign bi_ptr_o    = bi_q;
  assign level_o     = level;
  assign full_o      = full;
  assign empty_o     = empty;

endmodule

// File: tb/tb_scsi_dma_fifo.sv
// Self-checking bench for scsi_dma_fifo.
// - A behavioural model tracks the FIFO as a count plus read/write slots, and every output is
//   compared against it on each falling edge.
// - Directed sequences with literal expectations pin the model's behaviour.
// - A long randomized phase follows the directed sequences.
module tb_scsi_dma_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_clr = 1'b0, lw_we = 1'b0, byte_we = 1'b0;
  logic        incni = 1'b0, incno = 1'b0, incbo = 1'b0;
  logic [31:0] lw_din = '0;
  logic [7:0]  scsi_din = '0;
  logic [31:0] lw_dout;
  logic [7:0]  scsi_dout;
  logic [1:0]  bo_ptr, bi_ptr;
  logic [3:0]  level;
  logic        full, empty, ovf, unf;

  scsi_dma_fifo #(.Depth(8), .PtrW(3)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .fifo_clr_i  (fifo_clr),
    .lw_we_i     (lw_we),
    .lw_din_i    (lw_din),
    .byte_we_i   (byte_we),
    .scsi_din_i  (scsi_din),
    .incni_i     (incni),
    .incno_i     (incno),
    .incbo_i     (incbo),
    .lw_dout_o   (lw_dout),
    .scsi_dout_o (scsi_dout),
    .bo_ptr_o    (bo_ptr),
    .bi_ptr_o    (bi_ptr),
    .level_o     (level),
    .full_o      (full),
    .empty_o     (empty),
    .ovf_o       (ovf),
    .unf_o       (unf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model state: a count of occupied entries plus read/write slots modulo 8.
  logic [31:0] m_mem [8];
  int          m_wr = 0, m_rd = 0, m_cnt = 0, m_bi = 0, m_bo = 0;
  bit          m_ovf = 1'b0, m_unf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_wr = 0; m_rd = 0; m_cnt = 0; m_bi = 0; m_bo = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic model_step();
    bit was_full  = (m_cnt == 8);
    bit was_empty = (m_cnt == 0);
    int sh;
    if (fifo_clr) begin
      m_wr = 0; m_rd = 0; m_cnt = 0; m_bi = 0; m_bo = 0; m_ovf = 1'b0; m_unf = 1'b0;
      return;
    end
    if (!was_full) begin
      if (lw_we) begin
        m_mem[m_wr] = lw_din;
      end else if (byte_we) begin
        sh = 8 * (3 - m_bi);
        m_mem[m_wr] = (m_mem[m_wr] & ~(32'hFF << sh)) | (32'(scsi_din) << sh);
        m_bi = (m_bi + 1) % 4;
      end
    end
    if (incni) begin
      m_bi = 0;
      if (was_full) m_ovf = 1'b1;
      else begin
        m_wr = (m_wr + 1) % 8;
        m_cnt++;
      end
    end
    if (incno) begin
      m_bo = 0;
      if (was_empty) m_unf = 1'b1;
      else begin
        m_rd = (m_rd + 1) % 8;
        m_cnt--;
      end
    end else if (incbo) begin
      m_bo = (m_bo + 1) % 4;
    end
  endtask

  initial model_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("lw_dout", lw_dout, m_mem[m_rd]);
      check("scsi_dout", 32'(scsi_dout), (m_mem[m_rd] >> (8 * (3 - m_bo))) & 32'hFF);
      check("level", 32'(level), 32'(m_cnt));
      check("flags", {28'b0, full, empty, ovf, unf},
            {28'b0, m_cnt == 8, m_cnt == 0, m_ovf, m_unf});
      check("bi_bo", 32'({bi_ptr, bo_ptr}), 32'({2'(m_bi), 2'(m_bo)}));
    end
  end

  task automatic idle();
    fifo_clr = 1'b0; lw_we = 1'b0; byte_we = 1'b0;
    incni = 1'b0; incno = 1'b0; incbo = 1'b0;
  endtask

  // One clock: inputs set before the call are sampled at the next rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
    idle();
  endtask

  task automatic do_byte(input logic [7:0] b);
    byte_we = 1'b1; scsi_din = b; tick();
  endtask

  task automatic push_lw(input logic [31:0] d);
    lw_we = 1'b1; lw_din = d; incni = 1'b1; tick();
  endtask

  logic [7:0]  steps [4];
  logic [31:0] d;
  int          ph;

  initial begin
    steps[0] = 8'h11; steps[1] = 8'h22; steps[2] = 8'h33; steps[3] = 8'h44;
    #1 rst = 1'b1;
    #3;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_full_ovf_unf", 32'({full, ovf, unf}), 32'd0);
    check("rst_scsi_dout", 32'(scsi_dout), 32'h00);
    check("rst_lw_dout", lw_dout, 32'h0);
    @(negedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Byte packing and unpacking.
    for (int i = 0; i < 4; i++) do_byte(steps[i]);
    incni = 1'b1; tick();
    check("pack_lw", lw_dout, 32'h1122_3344);
    check("pack_level", 32'(level), 32'd1);
    check("pack_bi", 32'(bi_ptr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("unpack_byte", 32'(scsi_dout), 32'(steps[i]));
      if (i < 3) begin incbo = 1'b1; tick(); end
    end
    incno = 1'b1; tick();
    check("unpack_empty", 32'(empty), 32'd1);
    check("unpack_bo", 32'(bo_ptr), 32'd0);

    // Fill to full, then attempt an overflow.
    for (int i = 0; i < 8; i++) push_lw(32'hA000_0000 + 32'(i));
    push_lw(32'hDEAD_BEEF);
    check("full_flag", 32'(full), 32'd1);
    check("full_level", 32'(level), 32'd8);
    check("full_ovf", 32'(ovf), 32'd1);
    check("full_head", lw_dout, 32'hA000_0000);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", lw_dout, 32'hA000_0000 + 32'(i));
      incno = 1'b1; tick();
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Underflow.
    incno = 1'b1; tick();
    check("unf_flag", 32'(unf), 32'd1);
    check("unf_level", 32'(level), 32'd0);

    // Simultaneous operations.
    for (int i = 0; i < 3; i++) push_lw(32'h0B00_0000 + 32'(i));
    incni = 1'b1; incno = 1'b1; lw_we = 1'b1; lw_din = 32'hC0FF_EE00; tick();
    check("sim_level", 32'(level), 32'd3);
    incbo = 1'b1; tick();
    check("sim_bo_step", 32'(bo_ptr), 32'd1);
    incbo = 1'b1; incno = 1'b1; tick();
    check("sim_bo_clear", 32'(bo_ptr), 32'd0);
    check("sim_level2", 32'(level), 32'd2);
    fifo_clr = 1'b1; incni = 1'b1; tick();
    check("clr_level", 32'(level), 32'd0);
    check("clr_ovf_unf", 32'({ovf, unf}), 32'd0);

    // Single-entry fill/drain across several pointer wraps.
    for (int k = 0; k < 20; k++) begin
      d = $urandom;
      push_lw(d);
      check("wrap_data", lw_dout, d);
      check("wrap_level", 32'(level), 32'd1);
      incno = 1'b1; tick();
    end

    // Random phases alternately bias toward filling and toward draining.
    for (int n = 0; n < 3000; n++) begin
      ph = (n / 300) % 2;
      fifo_clr = ($urandom_range(0, 99) < 2);
      lw_we    = ($urandom_range(0, 3) == 0);
      byte_we  = ($urandom_range(0, 2) == 0);
      lw_din   = $urandom;
      scsi_din = 8'($urandom);
      incni    = (ph == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 4) == 0);
      incno    = (ph == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
      incbo    = ($urandom_range(0, 2) == 0);
      tick();
    end

    // Asynchronous reset in the middle of packing.
    fifo_clr = 1'b1; tick();
    push_lw(32'h1234_5678);
    do_byte(8'hAA);
    do_byte(8'hBB);
    check("mid_bi", 32'(bi_ptr), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_bi", 32'(bi_ptr), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_level", 32'(level), 32'd0);
    check("arst_lw_dout", lw_dout, 32'h0);
    @(negedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scsi_dma_fifo.md
Name: scsi_dma_fifo

Overview:
- Longword-wide DMA FIFO sitting between the host/DMA longword datapath and the 8-bit SCSI controller datapath.
- Consumes the pointer-control strobes that the SCSI state machine produces:
  - INCNI: increment next-in.
  - INCNO: increment next-out.
  - INCBO: increment byte-out.
  - Byte/longword write enables.
- Packs and unpacks bytes big-endian (68k order) and reports full/empty/level to the DMA control logic.

Parameters:
- DEPTH, 8, number of 32-bit entries; power of two, minimum 2.
- PTR_W, 3, log2(DEPTH); entry pointer width.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous active-high reset.
- FIFO_CLR  in  1  synchronous clear of pointers and flags.
- LW_WE  in  1  write LW_DIN into entry[NI] (all four lanes).
- LW_DIN  in  32  longword write data from host/DMA side.
- BYTE_WE  in  1  write SCSI_DIN into entry[NI], lane BI.
- SCSI_DIN  in  8  byte from SCSI controller (S2F path).
- INCNI  in  1  advance next-in pointer; clears BI.
- INCNO  in  1  advance next-out pointer; clears BO.
- INCBO  in  1  advance byte-out pointer.
- LW_DOUT  out  32  entry[NO], combinational read.
- SCSI_DOUT  out  8  lane BO of entry[NO] (F2S path).
- BO_PTR  out  2  current byte-out lane.
- BI_PTR  out  2  current byte-in lane.
- LEVEL  out  PTR_W+1  occupied entries, 0..DEPTH.
- FULL  out  1  LEVEL==DEPTH.
- EMPTY  out  1  LEVEL==0.
- OVF  out  1  sticky: INCNI attempted while FULL.
- UNF  out  1  sticky: INCNO attempted while EMPTY.

Behaviour:
- Reset (RST=1, async):
  - NI, NO, BI, BO = 0.
  - OVF, UNF = 0.
  - All storage = 0.
  - Outputs therefore: LEVEL=0, EMPTY=1, FULL=0, LW_DOUT=0, SCSI_DOUT=0.
  - Reset mid-transfer abandons all data; there is no recovery.
- Pointers:
  - NI and NO are PTR_W+1 bits: the MSB is the wrap bit, the low bits index storage and wrap modulo DEPTH.
  - LEVEL = NI − NO, computed modulo 2^(PTR_W+1).
- Lane mapping: lane 0 = bits 31:24, lane 1 = 23:16, lane 2 = 15:8, lane 3 = 7:0.
- Writes:
  - LW_WE writes all lanes of entry[NI[PTR_W-1:0]].
  - BYTE_WE writes lane BI only, then BI increments, wrapping 3→0.
  - If LW_WE and BYTE_WE are both asserted, LW_WE wins and BI is unchanged.
  - Writes while FULL are ignored, and the entry is unchanged.
- INCNI:
  - If not FULL: NI+1 and BI=0.
  - If FULL: NI unchanged, BI=0, OVF set.
  - A write and INCNI in the same cycle: the write lands in the old entry, then the pointer advances.
- INCBO: BO+1, wrapping 3→0; not gated by EMPTY.
- INCNO:
  - If not EMPTY: NO+1 and BO=0.
  - If EMPTY: NO unchanged, BO=0, UNF set.
  - INCNO together with INCBO: INCNO wins, BO=0.
- INCNI and INCNO in the same cycle:
  - Both advance and LEVEL is unchanged.
  - Evaluate FULL/EMPTY gating on pre-edge state. When EMPTY, INCNO is rejected, so only NI advances.
- Read latency: data written at edge k is visible on LW_DOUT/SCSI_DOUT after edge k, provided NO addresses that entry.
- FIFO_CLR (sync):
  - Zeroes NI, NO, BI, BO, OVF, UNF; storage is untouched.
  - Overrides every INC and write in the same cycle.
- Flags and LEVEL are combinational from registered pointers, so they are glitch-free relative to CLK.

Decomposition:
- Shared package scsi_fifo_pkg:
  - DEPTH/PTR_W defaults.
  - Lane index constants LANE0..LANE3 with bit ranges.
  - Function lane_sel(bo) returning the byte slice.
- One natural sub-module, scsi_fifo_ptr: a PTR_W+1 pointer with increment, gate, clear and sticky error. It is instantiated twice, for NI and NO.
- Storage and lane muxing stay in the top.

Test Plan:
- Reset → EMPTY=1, LEVEL=0, FULL=0, OVF=UNF=0, SCSI_DOUT=0x00.
- Byte packing:
  - Stimulus: BYTE_WE four times with 0x11, 0x22, 0x33, 0x44, then INCNI.
  - Required: LW_DOUT=0x11223344, LEVEL=1, BI_PTR=0.
  - Then INCBO ×3: SCSI_DOUT steps 0x11→0x22→0x33→0x44. Then INCNO: EMPTY=1, BO_PTR=0.
- Full/overflow:
  - Stimulus: 8× (LW_WE with 0xA0000000+i, then INCNI); then a ninth LW_WE 0xDEADBEEF + INCNI.
  - Required: FULL=1, LEVEL=8, OVF=1, entry[0] still 0xA0000000. Draining 8 entries yields 0xA0000000..0xA0000007 in order.
- Underflow: INCNO on empty FIFO → UNF=1, NO unchanged, LEVEL=0.
- Simultaneous operations:
  - With LEVEL=3, INCNI+INCNO together → LEVEL=3.
  - INCBO+INCNO together → BO_PTR=0.
  - FIFO_CLR with INCNI asserted → LEVEL=0, OVF=0.
- Wrap-around and async reset:
  - Run 20 fill/drain cycles of one entry each → data correct across the pointer wrap.
  - Assert RST between CLK edges mid-packing (BI=2) → BI_PTR=0 and EMPTY=1 immediately.
